// File: rtl/msm_point_fetch_ctrl.sv
// Point/scalar fetch sequencer for the MSM bucket kernel: reads x/y/z/k memories by shared index
// and streams one tuple per cycle over valid/ready, hiding the 1-cycle read latency with a 3-deep buffer.
module msm_point_fetch_ctrl #(
    parameter int unsigned EC_BASE_FIELD_WIDTH   = 377,
    parameter int unsigned EC_SCALAR_FIELD_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH            = 4,
    parameter int unsigned MEM_SIZE              = 16
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst_n,
    input  logic                             ap_start,
    input  logic [ADDR_WIDTH:0]              num_points,
    output logic                             ap_idle,
    output logic                             ap_done,
    output logic [ADDR_WIDTH-1:0]            mem_address0,
    output logic                             mem_ce0,
    output logic                             mem_we0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_x_q0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_y_q0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_z_q0,
    input  logic [EC_SCALAR_FIELD_WIDTH-1:0] K_q0,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_x,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_y,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_z,
    output logic [EC_SCALAR_FIELD_WIDTH-1:0] out_k,
    output logic [ADDR_WIDTH-1:0]            out_idx,
    output logic                             out_last
);

    localparam int unsigned   CW         = ADDR_WIDTH + 1;
    localparam int unsigned   DEPTH      = 3;
    localparam logic [CW-1:0] MEM_SIZE_C = CW'(MEM_SIZE);
    localparam logic [CW-1:0] ONE_C      = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [EC_BASE_FIELD_WIDTH-1:0]   x;
        logic [EC_BASE_FIELD_WIDTH-1:0]   y;
        logic [EC_BASE_FIELD_WIDTH-1:0]   z;
        logic [EC_SCALAR_FIELD_WIDTH-1:0] k;
        logic [ADDR_WIDTH-1:0]            idx;
    } entry_t;

    state_e                state_q, state_d;
    logic [CW-1:0]         n_q, n_d;
    logic [CW-1:0]         rd_idx_q, rd_idx_d;
    logic [CW-1:0]         acc_q, acc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] infl_idx_q, infl_idx_d;
    logic [1:0]            occ_q, occ_d;
    entry_t                buf_q [DEPTH];
    entry_t                buf_d [DEPTH];

    logic                  issue;
    logic                  pop;
    logic [CW-1:0]         n_start;
    logic [1:0]            wr_pos;
    entry_t                new_entry;

    assign n_start = (num_points > MEM_SIZE_C) ? MEM_SIZE_C : num_points;

    // Counts are registered, so an in-flight read always has a free slot waiting for it.
    assign issue = (state_q == S_RUN) && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
    assign pop   = (occ_q != 2'd0) && out_ready;

    assign new_entry = '{x: P_x_q0, y: P_y_q0, z: P_z_q0, k: K_q0, idx: infl_idx_q};

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        rd_idx_d   = issue ? rd_idx_q + ONE_C : rd_idx_q;
        acc_d      = pop ? acc_q + ONE_C : acc_q;
        inflight_d = issue;
        infl_idx_d = rd_idx_q[ADDR_WIDTH-1:0];
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    n_d      = n_start;
                    rd_idx_d = '0;
                    acc_d    = '0;
                    state_d  = (n_start == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (rd_idx_q == n_q - ONE_C)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (acc_q == n_q - ONE_C)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Shift-down buffer: head is always entry 0, a push lands just past the surviving entries.
    always_comb begin
        buf_d  = buf_q;
        wr_pos = pop ? occ_q - 2'd1 : occ_q;
        occ_d  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        if (pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                buf_d[i] = buf_q[i+1];
            end
        end
        if (inflight_q) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (2'(i) == wr_pos) begin
                    buf_d[i] = new_entry;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            rd_idx_q   <= '0;
            acc_q      <= '0;
            inflight_q <= 1'b0;
            infl_idx_q <= '0;
            occ_q      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            rd_idx_q   <= rd_idx_d;
            acc_q      <= acc_d;
            inflight_q <= inflight_d;
            infl_idx_q <= infl_idx_d;
            occ_q      <= occ_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign ap_idle      = (state_q == S_IDLE);
    assign ap_done      = (state_q == S_DONE);
    assign mem_ce0      = issue;
    assign mem_address0 = issue ? rd_idx_q[ADDR_WIDTH-1:0] : '0;
    assign mem_we0      = 1'b0;

    assign out_valid = (occ_q != 2'd0);
    assign out_x     = buf_q[0].x;
    assign out_y     = buf_q[0].y;
    assign out_z     = buf_q[0].z;
    assign out_k     = buf_q[0].k;
    assign out_idx   = buf_q[0].idx;
    assign out_last  = out_valid && ({1'b0, buf_q[0].idx} == n_q - ONE_C);

endmodule

// File: tb/tb_msm_point_fetch_ctrl.sv
// Bench for msm_point_fetch_ctrl: behavioural memories plus an expected-stream scoreboard
// (tuple i must carry mem[i], in order, for i < min(num_points,16)).
module tb_msm_point_fetch_ctrl;

    localparam int BW = 377;
    localparam int SW = 256;
    localparam int AW = 4;
    localparam int MS = 16;

    localparam int M_ALWAYS = 0;
    localparam int M_TOGGLE = 1;
    localparam int M_RANDOM = 2;
    localparam int M_HOLD   = 3;

    logic          clk;
    logic          rst_n;
    logic          ap_start;
    logic [AW:0]   num_points;
    logic          ap_idle;
    logic          ap_done;
    logic [AW-1:0] mem_address0;
    logic          mem_ce0;
    logic          mem_we0;
    logic [BW-1:0] px_q0, py_q0, pz_q0;
    logic [SW-1:0] k_q0;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_x, out_y, out_z;
    logic [SW-1:0] out_k;
    logic [AW-1:0] out_idx;
    logic          out_last;

    logic [BW-1:0] mx [MS];
    logic [BW-1:0] my [MS];
    logic [BW-1:0] mz [MS];
    logic [SW-1:0] mk [MS];

    int n_checks = 0;
    int n_fail   = 0;

    msm_point_fetch_ctrl #(
        .EC_BASE_FIELD_WIDTH  (BW),
        .EC_SCALAR_FIELD_WIDTH(SW),
        .ADDR_WIDTH           (AW),
        .MEM_SIZE             (MS)
    ) dut (
        .ap_clk      (clk),
        .ap_rst_n    (rst_n),
        .ap_start    (ap_start),
        .num_points  (num_points),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .mem_address0(mem_address0),
        .mem_ce0     (mem_ce0),
        .mem_we0     (mem_we0),
        .P_x_q0      (px_q0),
        .P_y_q0      (py_q0),
        .P_z_q0      (pz_q0),
        .K_q0        (k_q0),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_z       (out_z),
        .out_k       (out_k),
        .out_idx     (out_idx),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        if (mem_ce0) begin
            px_q0 <= mx[mem_address0];
            py_q0 <= my[mem_address0];
            pz_q0 <= mz[mem_address0];
            k_q0  <= mk[mem_address0];
        end
    end

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd_base();
        logic [383:0] r = '0;
        for (int i = 0; i < 12; i++) r = (r << 32) | 384'($urandom);
        return r[BW-1:0];
    endfunction

    function automatic logic [SW-1:0] rnd_scalar();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = (r << 32) | 256'($urandom);
        return r;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < MS; i++) begin
            mx[i] = rnd_base();
            my[i] = rnd_base();
            mz[i] = rnd_base();
            mk[i] = rnd_scalar();
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            M_ALWAYS: return 1'b1;
            M_TOGGLE: return (cyc % 2) == 1;
            M_RANDOM: return 1'($urandom_range(0, 1));
            default:  return cyc > 10;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idle"},  ap_idle, 1);
        chk({tag, "_done"},  ap_done, 0);
        chk({tag, "_ce0"},   mem_ce0, 0);
        chk({tag, "_addr"},  mem_address0, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"},  out_last, 0);
    endtask

    // One start/stream/done transaction; exp_done < 0 means the done cycle is not fixed.
    task automatic run_one(input int np, input int mode, input int exp_n, input int exp_done);
        int cyc, issued, accepted, done_cyc;
        bit prev_stall;
        logic [BW-1:0] sx, sy, sz;
        logic [SW-1:0] sk;
        logic [AW-1:0] si;
        string tg;
        tg = $sformatf("np%0d_m%0d", np, mode);
        fill_mem();
        @(negedge clk);
        chk({tg, "_idle_pre"}, ap_idle, 1);
        num_points = np[AW:0];
        ap_start   = 1'b1;
        out_ready  = ready_for(mode, 0);
        cyc = 0; issued = 0; accepted = 0; done_cyc = -1; prev_stall = 0;
        sx = '0; sy = '0; sz = '0; sk = '0; si = '0;
        while (done_cyc < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            ap_start  = 1'b0;
            out_ready = ready_for(mode, cyc);
            if (cyc == 1) chk({tg, "_idle_busy"}, ap_idle, 0);
            chk({tg, "_we0"}, mem_we0, 0);
            if (mem_ce0) begin
                chk({tg, "_rd_addr"}, mem_address0, issued);
                issued++;
            end
            chk({tg, "_outstanding_le3"}, (issued - accepted) <= 3, 1);
            if (out_valid) begin
                if (prev_stall) begin
                    chk({tg, "_stall_x"}, out_x, sx);
                    chk({tg, "_stall_y"}, out_y, sy);
                    chk({tg, "_stall_z"}, out_z, sz);
                    chk({tg, "_stall_k"}, out_k, sk);
                    chk({tg, "_stall_idx"}, out_idx, si);
                end
                if (accepted < exp_n) begin
                    chk({tg, "_idx"}, out_idx, accepted);
                    chk({tg, "_x"}, out_x, mx[accepted]);
                    chk({tg, "_y"}, out_y, my[accepted]);
                    chk({tg, "_z"}, out_z, mz[accepted]);
                    chk({tg, "_k"}, out_k, mk[accepted]);
                    chk({tg, "_last"}, out_last, accepted == exp_n - 1);
                end else begin
                    chk({tg, "_extra_tuple"}, accepted, exp_n - 1);
                end
                sx = out_x; sy = out_y; sz = out_z; sk = out_k; si = out_idx;
                prev_stall = !out_ready;
                if (out_ready) accepted++;
            end else begin
                prev_stall = 0;
            end
            if (mode == M_HOLD && cyc == 10) chk({tg, "_reads_while_blocked"}, issued, 3);
            if (ap_done) done_cyc = cyc;
        end
        if (done_cyc < 0) begin
            chk({tg, "_done_timeout"}, 0, 1);
        end else begin
            chk({tg, "_accepted"}, accepted, exp_n);
            chk({tg, "_issued"}, issued, exp_n);
            if (exp_done >= 0) chk({tg, "_done_cycle"}, done_cyc, exp_done);
        end
        @(negedge clk);
        chk({tg, "_idle_after"}, ap_idle, 1);
        chk({tg, "_done_pulse"}, ap_done, 0);
        chk({tg, "_valid_after"}, out_valid, 0);
    endtask

    typedef struct {
        int np;
        int mode;
        int exp_n;
        int exp_done;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{np: 4,  mode: M_ALWAYS, exp_n: 4,  exp_done: 7};
        vecs[1] = '{np: 16, mode: M_TOGGLE, exp_n: 16, exp_done: -1};
        vecs[2] = '{np: 0,  mode: M_ALWAYS, exp_n: 0,  exp_done: 1};
        vecs[3] = '{np: 20, mode: M_ALWAYS, exp_n: 16, exp_done: 19};
        vecs[4] = '{np: 8,  mode: M_HOLD,   exp_n: 8,  exp_done: 19};
        vecs[5] = '{np: 1,  mode: M_ALWAYS, exp_n: 1,  exp_done: 4};
        vecs[6] = '{np: 31, mode: M_RANDOM, exp_n: 16, exp_done: -1};
        vecs[7] = '{np: 3,  mode: M_RANDOM, exp_n: 3,  exp_done: -1};

        rst_n = 1'b0; ap_start = 1'b0; out_ready = 1'b0; num_points = '0;
        fill_mem();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_one(vecs[v].np, vecs[v].mode, vecs[v].exp_n, vecs[v].exp_done);
        end

        for (int r = 0; r < 6; r++) begin
            int np, md;
            np = $urandom_range(0, 31);
            md = $urandom_range(0, 2);
            run_one(np, md, (np > MS) ? MS : np, (md == M_ALWAYS) ? ((np == 0) ? 1 : ((np > MS) ? MS : np) + 3) : -1);
        end

        // Reset mid-run: outputs drop immediately and no done pulse follows.
        @(negedge clk);
        num_points = 5'd8;
        ap_start   = 1'b1;
        out_ready  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            ap_start = 1'b0;
        end
        @(negedge clk);
        chk("midrun_busy_before_reset", ap_idle, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("midrun_no_done", ap_done, 0);
            chk("midrun_held_idle", ap_idle, 1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_no_done", ap_done, 0);
        run_one(4, M_ALWAYS, 4, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
